// File: rtl/inst_mem_slave_if.sv
// AXI4 read-address / read-data channel bundle between the fetch master and inst_mem_slave.
interface inst_mem_slave_if #(
   parameter int C_S_AXI_ID_WIDTH     = 1,
   parameter int C_S_AXI_ADDR_WIDTH   = 32,
   parameter int C_S_AXI_DATA_WIDTH   = 32,
   parameter int C_S_AXI_ARUSER_WIDTH = 1,
   parameter int C_S_AXI_RUSER_WIDTH  = 4
);
   logic [C_S_AXI_ID_WIDTH-1:0]     S_AXI_ARID;
   logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR;
   logic [7:0]                      S_AXI_ARLEN;
   logic [2:0]                      S_AXI_ARSIZE;
   logic [1:0]                      S_AXI_ARBURST;
   logic [1:0]                      S_AXI_ARLOCK;
   logic [3:0]                      S_AXI_ARCACHE;
   logic [2:0]                      S_AXI_ARPROT;
   logic [3:0]                      S_AXI_ARQOS;
   logic [C_S_AXI_ARUSER_WIDTH-1:0] S_AXI_ARUSER;
   logic                            S_AXI_ARVALID;
   logic                            S_AXI_ARREADY;
   logic [C_S_AXI_ID_WIDTH-1:0]     S_AXI_RID;
   logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA;
   logic [1:0]                      S_AXI_RRESP;
   logic                            S_AXI_RLAST;
   logic [C_S_AXI_RUSER_WIDTH-1:0]  S_AXI_RUSER;
   logic                            S_AXI_RVALID;
   logic                            S_AXI_RREADY;

   modport master (
      output S_AXI_ARID, S_AXI_ARADDR, S_AXI_ARLEN, S_AXI_ARSIZE, S_AXI_ARBURST, S_AXI_ARLOCK,
             S_AXI_ARCACHE, S_AXI_ARPROT, S_AXI_ARQOS, S_AXI_ARUSER, S_AXI_ARVALID, S_AXI_RREADY,
      input  S_AXI_ARREADY, S_AXI_RID, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RLAST, S_AXI_RUSER,
             S_AXI_RVALID
   );

   modport slave (
      input  S_AXI_ARID, S_AXI_ARADDR, S_AXI_ARLEN, S_AXI_ARSIZE, S_AXI_ARBURST, S_AXI_ARLOCK,
             S_AXI_ARCACHE, S_AXI_ARPROT, S_AXI_ARQOS, S_AXI_ARUSER, S_AXI_ARVALID, S_AXI_RREADY,
      output S_AXI_ARREADY, S_AXI_RID, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RLAST, S_AXI_RUSER,
             S_AXI_RVALID
   );
endinterface

// File: rtl/inst_mem_slave.sv
// AXI4 read-only instruction memory: sync RAM, 2-entry R skid buffer, host load port.
// Optional macro INST_MEM_RANGE_CHECK_EN answers out-of-range beats with SLVERR instead of wrapping.
module inst_mem_slave #(
   parameter int C_S_AXI_ID_WIDTH   = 1,
   parameter int C_S_AXI_ADDR_WIDTH = 32,
   parameter int C_S_AXI_DATA_WIDTH = 32,
   parameter int MEM_WORDS          = 4096,
   parameter logic [C_S_AXI_ADDR_WIDTH-1:0] BASE_ADDR = 32'h2000_0000,
   localparam int AW = $clog2(MEM_WORDS)
) (
   input  logic                          CLK,
   input  logic                          RST,
   inst_mem_slave_if.slave               axi,
   input  logic                          LOAD_WE,
   input  logic [AW-1:0]                 LOAD_ADDR,
   input  logic [C_S_AXI_DATA_WIDTH-1:0] LOAD_DATA,
   output logic                          BUSY
);
`ifdef INST_MEM_RANGE_CHECK_EN
   localparam bit RANGE_CHECK = 1'b1;
`else
   localparam bit RANGE_CHECK = 1'b0;
`endif
   localparam logic [C_S_AXI_ADDR_WIDTH-1:0] SPAN = C_S_AXI_ADDR_WIDTH'(4 * MEM_WORDS);

   typedef enum logic [1:0] {IDLE, BURST, DRAIN} state_t;

   typedef struct packed {
      logic [C_S_AXI_DATA_WIDTH-1:0] data;
      logic [1:0]                    resp;
      logic                          last;
   } beat_t;

   state_t                          state;
   logic                            arready_q, busy_q, fixed_q, oob_q;
   logic [C_S_AXI_ID_WIDTH-1:0]     rid_q;
   logic [AW-1:0]                   idx;
   logic [7:0]                      cnt;
   logic                            p_valid, p_last, p_err;
   logic [C_S_AXI_DATA_WIDTH-1:0]   ram_q;
   logic [C_S_AXI_DATA_WIDTH-1:0]   mem [MEM_WORDS];
   beat_t                           out_b, skid_b, push_b;
   logic                            out_v, skid_v, pop, issue, start_oob;
   logic [1:0]                      occ;
   logic [C_S_AXI_ADDR_WIDTH-1:0]   off;

   assign off       = axi.S_AXI_ARADDR - BASE_ADDR;
   assign start_oob = RANGE_CHECK && (off >= SPAN);
   assign pop       = out_v && axi.S_AXI_RREADY;

   // Entries held or in flight; a read may issue only if it is guaranteed a buffer slot.
   assign occ   = 2'(out_v) + 2'(skid_v) + 2'(p_valid);
   assign issue = (state == BURST) && ((occ <= 2'd1) || ((occ == 2'd2) && pop));

   always_ff @(posedge CLK or negedge RST) begin
      // NOTE: all clocked state uses non-blocking assignments so every register samples pre-edge values.
      if (!RST) begin
         state     <= IDLE;
         arready_q <= 1'b0;
         busy_q    <= 1'b0;
         rid_q     <= '0;
         idx       <= '0;
         cnt       <= '0;
         fixed_q   <= 1'b0;
         oob_q     <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (axi.S_AXI_ARVALID && arready_q) begin
                  rid_q     <= axi.S_AXI_ARID;
                  idx       <= off[AW+1:2];
                  cnt       <= axi.S_AXI_ARLEN;
                  fixed_q   <= (axi.S_AXI_ARBURST == 2'b00);
                  oob_q     <= start_oob;
                  arready_q <= 1'b0;
                  busy_q    <= 1'b1;
                  state     <= BURST;
               end else begin
                  arready_q <= 1'b1;
               end
            end
            BURST: begin
               if (issue) begin
                  if (!fixed_q) begin
                     idx <= idx + AW'(1);
                     if (RANGE_CHECK && (idx == '1)) oob_q <= 1'b1;
                  end
                  if (cnt == 8'd0) state <= DRAIN;
                  else             cnt   <= cnt - 8'd1;
               end
            end
            DRAIN: begin
               if (pop && out_b.last) begin
                  state     <= IDLE;
                  arready_q <= 1'b1;
                  busy_q    <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // NOTE: the RAM array and its read register carry no reset; contents must survive RST.
   always_ff @(posedge CLK) begin
      if (LOAD_WE) mem[LOAD_ADDR] <= LOAD_DATA;
      if (issue)   ram_q <= mem[idx];
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         p_valid <= 1'b0;
         p_last  <= 1'b0;
         p_err   <= 1'b0;
      end else begin
         p_valid <= issue;
         if (issue) begin
            p_last <= (cnt == 8'd0);
            p_err  <= oob_q;
         end
      end
   end

   always_comb begin
      // NOTE: default the whole struct first so no path leaves a field unassigned (no latch).
      push_b      = '0;
      push_b.data = p_err ? '0 : ram_q;
      push_b.resp = p_err ? 2'b10 : 2'b00;
      push_b.last = p_last;
   end

   // Output register plus skid: head moves on a pop or when empty, skid catches the in-flight read.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         out_v  <= 1'b0;
         skid_v <= 1'b0;
         out_b  <= '0;
         skid_b <= '0;
      end else if (!out_v || pop) begin
         if (skid_v) begin
            out_b  <= skid_b;
            out_v  <= 1'b1;
            skid_v <= p_valid;
            if (p_valid) skid_b <= push_b;
         end else begin
            out_v <= p_valid;
            if (p_valid) out_b <= push_b;
         end
      end else if (p_valid) begin
         skid_v <= 1'b1;
         skid_b <= push_b;
      end
   end

   assign axi.S_AXI_ARREADY = arready_q;
   assign axi.S_AXI_RVALID  = out_v;
   assign axi.S_AXI_RDATA   = out_b.data;
   assign axi.S_AXI_RRESP   = out_b.resp;
   assign axi.S_AXI_RLAST   = out_b.last;
   assign axi.S_AXI_RID     = rid_q;
   assign axi.S_AXI_RUSER   = '0;
   assign BUSY              = busy_q;

   logic unused_ok;
   assign unused_ok = &{1'b0, axi.S_AXI_ARSIZE, axi.S_AXI_ARLOCK, axi.S_AXI_ARCACHE,
                        axi.S_AXI_ARPROT, axi.S_AXI_ARQOS, axi.S_AXI_ARUSER, off[1:0],
                        off[C_S_AXI_ADDR_WIDTH-1:AW+2]};
endmodule

// File: tb/tb_inst_mem_slave.sv
// Scoreboard bench for inst_mem_slave: expected beats queued at AR time, compared as R beats retire.
module tb_inst_mem_slave;
   localparam int MEM_WORDS = 4096;
   localparam int AW = $clog2(MEM_WORDS);
   localparam logic [31:0] BASE = 32'h2000_0000;
`ifdef INST_MEM_RANGE_CHECK_EN
   localparam bit RC = 1'b1;
`else
   localparam bit RC = 1'b0;
`endif

   typedef struct packed {
      logic [31:0] data;
      logic [1:0]  resp;
      logic        last;
      logic [0:0]  id;
   } beat_t;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          load_we = 1'b0;
   logic [AW-1:0] load_addr = '0;
   logic [31:0]   load_data = '0;
   logic          busy;
   logic [31:0]   model [MEM_WORDS];
   beat_t         exp_q[$];
   int            errors = 0;
   int            checks = 0;
   bit            pat [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

   inst_mem_slave_if axi ();

   inst_mem_slave dut (
      .CLK(clk), .RST(rst), .axi(axi),
      .LOAD_WE(load_we), .LOAD_ADDR(load_addr), .LOAD_DATA(load_data), .BUSY(busy)
   );

   always #5 clk = ~clk;

   task automatic load_word(input int w, input logic [31:0] d);
      @(negedge clk);
      load_we = 1'b1; load_addr = AW'(w); load_data = d;
      @(negedge clk);
      load_we = 1'b0;
      model[w] = d;
   endtask

   function automatic void expect_burst(input logic [31:0] addr, input int len,
                                        input logic [1:0] burst, input logic id);
      logic [31:0] off;
      bit inr;
      int w0, lin;
      beat_t b;
      off = addr - BASE;
      inr = off < 32'(4 * MEM_WORDS);
      w0  = int'(off[31:2]) % MEM_WORDS;
      for (int i = 0; i <= len; i++) begin
         lin    = (burst == 2'b00) ? w0 : w0 + i;
         b.id   = id;
         b.last = (i == len);
         if (RC && (!inr || lin >= MEM_WORDS)) begin
            b.data = '0; b.resp = 2'b10;
         end else begin
            b.data = model[lin % MEM_WORDS]; b.resp = 2'b00;
         end
         exp_q.push_back(b);
      end
   endfunction

   // Called at a negedge; returns at the negedge right after the AR handshake.
   task automatic send_ar(input logic [31:0] addr, input int len, input logic [1:0] burst,
                          input logic id);
      int w = 0;
      while (!axi.S_AXI_ARREADY && w < 100) begin
         @(negedge clk); w++;
      end
      if (w >= 100) begin
         checks++; errors++;
         $display("FAIL ar_wait: ARREADY stayed %b, want 1 within 100 cycles", axi.S_AXI_ARREADY);
      end
      axi.S_AXI_ARADDR  = addr;
      axi.S_AXI_ARLEN   = 8'(len);
      axi.S_AXI_ARBURST = burst;
      axi.S_AXI_ARID    = id;
      axi.S_AXI_ARVALID = 1'b1;
      expect_burst(addr, len, burst, id);
      @(negedge clk);
      axi.S_AXI_ARVALID = 1'b0;
   endtask

   // R monitor: drives RREADY per mode (0 always, 1 fixed pattern, 2 random) and scores beats.
   task automatic capture(input string name, input int n, input int mode, output int lat,
                          output bit stable, output logic ar_last, output logic ar_after,
                          output logic rv_after);
      int got = 0;
      int cyc = 0;
      bit pv = 1'b0;
      bit pr = 1'b0;
      beat_t pb = '0;
      beat_t cur, e;
      lat = -1; stable = 1'b1; ar_last = 1'bx;
      while (got < n && cyc < 3000) begin
         case (mode)
            0:       axi.S_AXI_RREADY = 1'b1;
            1:       axi.S_AXI_RREADY = pat[cyc % 6];
            default: axi.S_AXI_RREADY = 1'($urandom_range(0, 1));
         endcase
         cur = '{data: axi.S_AXI_RDATA, resp: axi.S_AXI_RRESP, last: axi.S_AXI_RLAST,
                 id: axi.S_AXI_RID};
         if (axi.S_AXI_RVALID && lat < 0) lat = cyc;
         if (pv && !pr && (!axi.S_AXI_RVALID || cur !== pb)) stable = 1'b0;
         if (axi.S_AXI_RVALID && axi.S_AXI_RREADY) begin
            got++;
            if (got == n) ar_last = axi.S_AXI_ARREADY;
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL %s beat %0d: got extra beat data=%h, want no beat", name, got, cur.data);
            end else begin
               e = exp_q.pop_front();
               if (cur !== e)
                  begin
                     errors++;
                     $display("FAIL %s beat %0d: got data=%h resp=%b last=%b id=%b, want data=%h resp=%b last=%b id=%b",
                              name, got, cur.data, cur.resp, cur.last, cur.id, e.data, e.resp, e.last, e.id);
                  end
            end
         end
         pv = axi.S_AXI_RVALID; pr = axi.S_AXI_RREADY; pb = cur;
         @(negedge clk); cyc++;
      end
      axi.S_AXI_RREADY = 1'b0;
      if (got < n) begin
         checks++; errors++;
         $display("FAIL %s timeout: got %0d beats, want %0d", name, got, n);
         exp_q.delete();
      end
      ar_after = axi.S_AXI_ARREADY;
      rv_after = axi.S_AXI_RVALID;
   endtask

   task automatic test_reset();
      #12;
      checks += 7;
      if (axi.S_AXI_ARREADY !== 1'b0) begin errors++; $display("FAIL rst_arready: got %b want 0", axi.S_AXI_ARREADY); end
      if (axi.S_AXI_RVALID !== 1'b0) begin errors++; $display("FAIL rst_rvalid: got %b want 0", axi.S_AXI_RVALID); end
      if (axi.S_AXI_RLAST !== 1'b0) begin errors++; $display("FAIL rst_rlast: got %b want 0", axi.S_AXI_RLAST); end
      if (axi.S_AXI_RDATA !== 32'h0) begin errors++; $display("FAIL rst_rdata: got %h want 0", axi.S_AXI_RDATA); end
      if (axi.S_AXI_RRESP !== 2'b00) begin errors++; $display("FAIL rst_rresp: got %b want 00", axi.S_AXI_RRESP); end
      if (axi.S_AXI_RID !== 1'b0) begin errors++; $display("FAIL rst_rid: got %b want 0", axi.S_AXI_RID); end
      if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", busy); end
      @(negedge clk);
      rst = 1'b1;
      #1;
      checks++;
      if (axi.S_AXI_ARREADY !== 1'b0) begin errors++; $display("FAIL rel_arready_pre: got %b want 0", axi.S_AXI_ARREADY); end
      @(negedge clk);
      checks++;
      if (axi.S_AXI_ARREADY !== 1'b1) begin errors++; $display("FAIL rel_arready_post: got %b want 1", axi.S_AXI_ARREADY); end
   endtask

   task automatic test_single();
      int lat; bit st; logic arl, ara, rva;
      load_word(0, 32'h0000_0013);
      send_ar(BASE, 0, 2'b01, 1'b1);
      checks += 2;
      if (busy !== 1'b1) begin errors++; $display("FAIL single_busy: got %b want 1", busy); end
      if (axi.S_AXI_ARREADY !== 1'b0) begin errors++; $display("FAIL single_arready_busy: got %b want 0", axi.S_AXI_ARREADY); end
      capture("single", 1, 0, lat, st, arl, ara, rva);
      checks += 4;
      if (lat !== 2) begin errors++; $display("FAIL single_latency: got %0d want 2", lat); end
      if (arl !== 1'b0) begin errors++; $display("FAIL single_arready_at_last: got %b want 0", arl); end
      if (ara !== 1'b1) begin errors++; $display("FAIL single_arready_after: got %b want 1", ara); end
      if (rva !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL single_idle_after: got rvalid=%b busy=%b want 0/0", rva, busy); end
   endtask

   task automatic test_incr();
      int lat; bit st; logic arl, ara, rva;
      for (int i = 0; i < 4; i++) load_word(4 + i, 32'(i + 1));
      send_ar(BASE + 32'h10, 3, 2'b01, 1'b0);
      capture("incr", 4, 0, lat, st, arl, ara, rva);
      checks += 3;
      if (lat !== 2) begin errors++; $display("FAIL incr_latency: got %0d want 2", lat); end
      if (ara !== 1'b1) begin errors++; $display("FAIL incr_arready_after: got %b want 1", ara); end
      if (rva !== 1'b0) begin errors++; $display("FAIL incr_rvalid_after: got %b want 0", rva); end
   endtask

   task automatic test_backpressure();
      int lat; bit st; logic arl, ara, rva;
      send_ar(BASE + 32'h10, 3, 2'b01, 1'b1);
      capture("bp", 4, 1, lat, st, arl, ara, rva);
      checks += 3;
      if (!st) begin errors++; $display("FAIL bp_stable: got unstable R payload while stalled, want stable"); end
      if (lat !== 2) begin errors++; $display("FAIL bp_latency: got %0d want 2", lat); end
      if (rva !== 1'b0) begin errors++; $display("FAIL bp_rvalid_after: got %b want 0", rva); end
   endtask

   task automatic test_fixed_and_wrap();
      int lat; bit st; logic arl, ara, rva;
      send_ar(BASE + 32'h14, 2, 2'b00, 1'b1);
      capture("fixed", 3, 0, lat, st, arl, ara, rva);
      load_word(MEM_WORDS - 1, 32'hCAFE_F00D);
      send_ar(BASE + 32'(4 * (MEM_WORDS - 1)), 1, 2'b01, 1'b0);
      capture("wrap", 2, 0, lat, st, arl, ara, rva);
      checks++;
      if (lat !== 2) begin errors++; $display("FAIL wrap_latency: got %0d want 2", lat); end
   endtask

   task automatic test_reset_mid_burst();
      int lat; bit st; logic arl, ara, rva;
      send_ar(BASE + 32'h10, 3, 2'b01, 1'b1);
      capture("rst_mid", 2, 0, lat, st, arl, ara, rva);
      rst = 1'b0;
      #1;
      exp_q.delete();
      checks += 2;
      if (axi.S_AXI_RVALID !== 1'b0) begin errors++; $display("FAIL rst_mid_rvalid: got %b want 0", axi.S_AXI_RVALID); end
      if (axi.S_AXI_ARREADY !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL rst_mid_arready_busy: got %b/%b want 0/0", axi.S_AXI_ARREADY, busy); end
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      checks++;
      if (axi.S_AXI_ARREADY !== 1'b1) begin errors++; $display("FAIL rst_mid_arready_release: got %b want 1", axi.S_AXI_ARREADY); end
      send_ar(BASE, 0, 2'b01, 1'b0);
      capture("rst_mid_reread", 1, 0, lat, st, arl, ara, rva);
      checks++;
      if (lat !== 2) begin errors++; $display("FAIL rst_mid_latency: got %0d want 2", lat); end
   endtask

   task automatic test_back_to_back();
      int lat; bit st; logic arl, ara, rva;
      int w, len;
      logic [1:0] bt;
      for (int i = 8; i < 64; i++) load_word(i, $urandom);
      for (int k = 0; k < 8; k++) begin
         w   = $urandom_range(8, 47);
         len = $urandom_range(0, 15);
         bt  = 2'($urandom_range(0, 2));
         send_ar(BASE + 32'(4 * w), len, bt, 1'(k));
         capture("b2b", len + 1, 2, lat, st, arl, ara, rva);
         checks += 2;
         if (!st) begin errors++; $display("FAIL b2b_stable %0d: got unstable R payload, want stable", k); end
         if (lat !== 2) begin errors++; $display("FAIL b2b_latency %0d: got %0d want 2", k, lat); end
      end
   endtask

   task automatic test_long_burst();
      int lat; bit st; logic arl, ara, rva;
      for (int i = 256; i < 512; i++) load_word(i, 32'(i * 3 + 7));
      send_ar(BASE + 32'(4 * 256), 255, 2'b01, 1'b1);
      capture("len255", 256, 2, lat, st, arl, ara, rva);
      checks += 2;
      if (!st) begin errors++; $display("FAIL len255_stable: got unstable R payload, want stable"); end
      if (rva !== 1'b0) begin errors++; $display("FAIL len255_rvalid_after: got %b want 0", rva); end
   endtask

`ifdef INST_MEM_RANGE_CHECK_EN
   task automatic test_range();
      int lat; bit st; logic arl, ara, rva;
      send_ar(32'h1000_0000, 1, 2'b01, 1'b1);
      capture("range_low", 2, 0, lat, st, arl, ara, rva);
      checks++;
      if (lat !== 2) begin errors++; $display("FAIL range_latency: got %0d want 2", lat); end
      send_ar(BASE + 32'(4 * (MEM_WORDS - 2)), 3, 2'b01, 1'b0);
      capture("range_cross", 4, 1, lat, st, arl, ara, rva);
   endtask
`endif

   initial begin
      axi.S_AXI_ARID = '0; axi.S_AXI_ARADDR = '0; axi.S_AXI_ARLEN = '0; axi.S_AXI_ARSIZE = 3'd2;
      axi.S_AXI_ARBURST = 2'b01; axi.S_AXI_ARLOCK = '0; axi.S_AXI_ARCACHE = '0;
      axi.S_AXI_ARPROT = '0; axi.S_AXI_ARQOS = '0; axi.S_AXI_ARUSER = '0;
      axi.S_AXI_ARVALID = 1'b0; axi.S_AXI_RREADY = 1'b0;
      test_reset();
      test_single();
      test_incr();
      test_backpressure();
      test_fixed_and_wrap();
      test_reset_mid_burst();
      test_back_to_back();
      test_long_burst();
`ifdef INST_MEM_RANGE_CHECK_EN
      test_range();
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #500_000;
      $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
      $fatal(1);
   end
endmodule
